game_tick_scheduler: RTL and testbench
======================================

Name: game_tick_scheduler

Overview:
Sequences the game's time base. Divides sysclk into single-cycle "tick" enables, replacing free-running toggled clocks, so all game logic stays on one clock. Tick rate ramps up over play time (difficulty ramp, saturating at a minimum period) under a start/pause/game-over FSM. Feeds the obstacle mover, score counter and animation logic.

Parameters:
CNT_W, 24, width of period/interval counter
INIT_PERIOD, 1666667, sysclk cycles per tick at game start (60 Hz at 100 MHz)
MIN_PERIOD, 416667, floor for the period (240 Hz); must satisfy 2 <= MIN_PERIOD <= INIT_PERIOD < 2**CNT_W
STEP, 20833, period decrement per ramp event
RAMP_TICKS, 600, ticks between ramp events; must be >= 1
RAMP_W, 10, width of ramp tick counter; 2**RAMP_W >= RAMP_TICKS

Ports:
sysclk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
start  in  1  level, sampled each cycle; begins or restarts a game from IDLE/OVER
pause  in  1  level; high freezes timing while in RUN/PAUSED
game_over  in  1  level; ends the game from RUN/PAUSED
tick  out  1  registered; one-cycle enable pulse per period
ramp_evt  out  1  registered; one-cycle pulse when the period was just shortened
period_out  out  CNT_W  current period in effect
state_out  out  2  0=IDLE 1=RUN 2=PAUSED 3=OVER
running  out  1  high only in RUN

Behaviour:
- Reset (async, immediate, no clock needed): state IDLE, tick=0, ramp_evt=0, interval counter=0, ramp counter=0, period_out=INIT_PERIOD, running=0.
- IDLE: no ticks. start=1 -> RUN; load period=INIT_PERIOD, counter=0, ramp counter=0.
- RUN: counter increments each cycle. When counter==period-1: counter<=0, tick<=1 next cycle, ramp counter increments.
- First tick is asserted exactly INIT_PERIOD cycles after the edge that sampled start. Later ticks are exactly period cycles apart.
- Ramp: on a tick where ramp counter==RAMP_TICKS-1: ramp counter<=0, ramp_evt<=1 (same cycle as tick). Period becomes MIN_PERIOD if period < MIN_PERIOD+STEP, else period-STEP. Compute in CNT_W+1 bits; no wrap. The new period governs the next interval; the one just ended is unaffected.
- Period never goes below MIN_PERIOD. Once saturated, ramp_evt still pulses and period_out holds.
- PAUSED: entered from RUN when pause=1. Counter, ramp counter and period are frozen; no tick, no ramp_evt. Returns to RUN when pause=0, resuming from the frozen count.
- Terminal count coinciding with pause: pause wins; no tick, counter stays at period-1, and the tick fires on the first RUN cycle after resume.
- OVER: entered from RUN/PAUSED when game_over=1. No ticks; period_out holds its last value. start=1 -> RUN with full reinit, as from IDLE.
- Priority in RUN/PAUSED: game_over > pause > terminal-count tick. A terminal count in the same cycle as game_over produces no tick and no ramp_evt.
- start is ignored in RUN/PAUSED. pause is ignored in IDLE/OVER. game_over is ignored in IDLE/OVER.
- tick and ramp_evt are never high for more than one consecutive cycle (MIN_PERIOD >= 2).

Decomposition:
- Package game_timing_pkg holds:
  - state enum (IDLE, RUN, PAUSED, OVER) with fixed 2-bit encoding
  - default period constants for 100 MHz
  - a helper function for the saturating period decrement
- One natural sub-module: interval_counter. It is a loadable CNT_W counter with enable and a terminal-count output for a variable limit. It is reused by the scheduler and available to other timing blocks.
- The FSM and ramp logic stay in game_tick_scheduler.

Test Plan:
(bench params: INIT_PERIOD=10, MIN_PERIOD=4, STEP=3, RAMP_TICKS=2, CNT_W=8, RAMP_W=2)
1. Reset, then idle 50 cycles -> tick=0, ramp_evt=0, state_out=0, period_out=10, running=0 throughout.
2. One-cycle start pulse -> ticks at cycles 10, 20; ramp_evt with the 2nd tick and period_out=7; ticks at 27, 34; period 4; then ticks at 38, 42, then every 4 cycles with period_out held at 4.
3. Hold pause for 25 cycles, beginning 3 cycles after a tick (period 10) -> state_out=2, no ticks; after release the next tick arrives 10+25 cycles after the previous one.
4. Assert game_over on the cycle the counter reaches period-1 -> no tick, no ramp_evt, state_out=3; then start -> state_out=1, period_out=10, first tick 10 cycles later.
5. Assert reset asynchronously between clock edges during RUN -> tick, ramp_evt and running drop to 0 and state_out=0 before the next edge; period_out=10.
6. In RUN, pulse start -> ignored, tick spacing unchanged. Then assert pause and game_over in the same cycle -> state_out=3, no further ticks.

Source files
------------

// File: rtl/game_timing_pkg.sv
// Shared timing types and constants for the game time base.
package game_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

  // Default periods for a 100 MHz sysclk.
  localparam int DEF_CNT_W       = 24;
  localparam int DEF_INIT_PERIOD = 1666667;  // 60 Hz
  localparam int DEF_MIN_PERIOD  = 416667;   // 240 Hz
  localparam int DEF_STEP        = 20833;
  localparam int DEF_RAMP_TICKS  = 600;
  localparam int DEF_RAMP_W      = 10;

  // Saturating period decrement. Operands are one bit wider than any counter
  // up to 32 bits, so the min+step compare can never wrap.
  function automatic logic [32:0] sat_dec(input logic [32:0] period,
                                          input logic [32:0] min_p,
                                          input logic [32:0] step);
    if (period < min_p + step) sat_dec = min_p;
    else                       sat_dec = period - step;
  endfunction

endpackage

// File: rtl/interval_counter.sv
// Loadable up-counter that wraps to zero at a run-time limit and flags the
// terminal count (count == limit-1) combinationally.
module interval_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_d, count_q;

  assign tc    = (count_q == limit - CNT_W'(1));
  assign count = count_q;

  // Next count: load has priority, then enabled increment with wrap.
  always_comb begin
    count_d = count_q;
    if (load)    count_d = load_val;
    else if (en) count_d = tc ? '0 : count_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Game time base: single-clock tick enables with a difficulty ramp that
// shortens the period, under a start/pause/game-over FSM.
module game_tick_scheduler
  import game_timing_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int INIT_PERIOD = DEF_INIT_PERIOD,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int STEP        = DEF_STEP,
  parameter int RAMP_TICKS  = DEF_RAMP_TICKS,
  parameter int RAMP_W      = DEF_RAMP_W
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             game_over,
  output logic             tick,
  output logic             ramp_evt,
  output logic [CNT_W-1:0] period_out,
  output logic [1:0]       state_out,
  output logic             running
);

  localparam logic [CNT_W-1:0]  INIT_P    = CNT_W'(INIT_PERIOD);
  localparam logic [32:0]       MIN_P33   = 33'(MIN_PERIOD);
  localparam logic [32:0]       STEP33    = 33'(STEP);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  period_d, period_q;
  logic [RAMP_W-1:0] ramp_d, ramp_q;
  logic              tick_d, tick_q;
  logic              ramp_evt_d, ramp_evt_q;
  logic              cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0]  cnt_val;

  interval_counter #(.CNT_W(CNT_W)) u_interval (
    .clk      (sysclk),
    .rst      (reset),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .limit    (period_q),
    .count    (cnt_val),
    .tc       (cnt_tc)
  );

  // FSM next state, counter control, tick and ramp decisions.
  // In PAUSED with pause released the cycle already counts, so a pause of
  // N sampled cycles delays the next tick by exactly N.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    ramp_d     = ramp_q;
    tick_d     = 1'b0;
    ramp_evt_d = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d  = ST_RUN;
          period_d = INIT_P;
          ramp_d   = '0;
          cnt_load = 1'b1;
        end
      end
      ST_RUN, ST_PAUSED: begin
        if (game_over) begin
          state_d = ST_OVER;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_RUN;
          cnt_en  = 1'b1;
          if (cnt_tc) begin
            tick_d = 1'b1;
            if (ramp_q == RAMP_LAST) begin
              ramp_d     = '0;
              ramp_evt_d = 1'b1;
              period_d   = CNT_W'(sat_dec(33'(period_q), MIN_P33, STEP33));
            end else begin
              ramp_d = ramp_q + RAMP_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, period, ramp count and registered pulse outputs.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      period_q   <= INIT_P;
      ramp_q     <= '0;
      tick_q     <= 1'b0;
      ramp_evt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      ramp_q     <= ramp_d;
      tick_q     <= tick_d;
      ramp_evt_q <= ramp_evt_d;
    end
  end

  assign tick       = tick_q;
  assign ramp_evt   = ramp_evt_q;
  assign period_out = period_q;
  assign state_out  = state_q;
  assign running    = (state_q == ST_RUN);

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with small periods.
module tb_game_tick_scheduler;

  localparam int CNT_W = 8;

  logic             sysclk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             game_over = 1'b0;
  logic             tick, ramp_evt, running;
  logic [CNT_W-1:0] period_out;
  logic [1:0]       state_out;

  int errors = 0;
  int checks = 0;
  int k = 0;

  game_tick_scheduler #(
    .CNT_W(CNT_W), .INIT_PERIOD(10), .MIN_PERIOD(4), .STEP(3),
    .RAMP_TICKS(2), .RAMP_W(2)
  ) dut (
    .sysclk(sysclk), .reset(reset), .start(start), .pause(pause),
    .game_over(game_over), .tick(tick), .ramp_evt(ramp_evt),
    .period_out(period_out), .state_out(state_out), .running(running)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic       st, pa, go;
    logic [1:0] exp_state;
  } fsm_vec_t;

  typedef struct {
    int   edge_n;
    logic exp_ramp;
    int   exp_period;
  } tick_vec_t;

  fsm_vec_t  fsm_tab[12];
  tick_vec_t tick_tab[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; pause = 1'b0; game_over = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    reset = 1'b0;
    k = 0;
  endtask

  // Pulse start for one sampled edge; afterwards k==0 is that edge.
  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
  endtask

  // Step to edge 'target': no pulses before it, tick with given ramp/period at it.
  task automatic expect_tick_at(input int target, input logic exp_ramp, input int exp_period);
    while (k < target) begin
      step();
      if (k < target) begin
        chk("no_tick", 32'(tick), 0);
        chk("no_ramp", 32'(ramp_evt), 0);
      end else begin
        chk("tick", 32'(tick), 1);
        chk("ramp_evt", 32'(ramp_evt), 32'(exp_ramp));
        chk("period", 32'(period_out), 32'(exp_period));
      end
    end
  endtask

  initial begin
    fsm_tab[0]  = '{0, 1, 0, 2'd0};  // pause ignored in IDLE
    fsm_tab[1]  = '{0, 0, 1, 2'd0};  // game_over ignored in IDLE
    fsm_tab[2]  = '{1, 0, 0, 2'd1};
    fsm_tab[3]  = '{1, 0, 0, 2'd1};  // start ignored in RUN
    fsm_tab[4]  = '{0, 1, 0, 2'd2};
    fsm_tab[5]  = '{1, 1, 0, 2'd2};  // start ignored in PAUSED
    fsm_tab[6]  = '{0, 0, 0, 2'd1};
    fsm_tab[7]  = '{0, 0, 1, 2'd3};
    fsm_tab[8]  = '{0, 1, 0, 2'd3};  // pause ignored in OVER
    fsm_tab[9]  = '{0, 0, 1, 2'd3};
    fsm_tab[10] = '{1, 0, 0, 2'd1};  // restart from OVER
    fsm_tab[11] = '{0, 1, 1, 2'd3};  // game_over beats pause

    tick_tab[0] = '{10, 0, 10};
    tick_tab[1] = '{20, 1, 7};
    tick_tab[2] = '{27, 0, 7};
    tick_tab[3] = '{34, 1, 4};
    tick_tab[4] = '{38, 0, 4};
    tick_tab[5] = '{42, 1, 4};
    tick_tab[6] = '{46, 0, 4};
    tick_tab[7] = '{50, 1, 4};

    // 1: reset (async) then idle
    #2 reset = 1'b1;
    #1;
    chk("rst_state", 32'(state_out), 0);
    chk("rst_period", 32'(period_out), 10);
    chk("rst_tick", 32'(tick), 0);
    do_reset();
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_tick", 32'(tick), 0);
      chk("idle_ramp", 32'(ramp_evt), 0);
      chk("idle_state", 32'(state_out), 0);
      chk("idle_period", 32'(period_out), 10);
      chk("idle_running", 32'(running), 0);
    end

    // FSM table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      start = fsm_tab[i].st; pause = fsm_tab[i].pa; game_over = fsm_tab[i].go;
      step();
      chk("fsm_state", 32'(state_out), 32'(fsm_tab[i].exp_state));
      chk("fsm_running", 32'(running), 32'(fsm_tab[i].exp_state == 2'd1));
      chk("fsm_tick", 32'(tick), 0);
      chk("fsm_period", 32'(period_out), 10);
    end

    // 2: ramp sequence down to saturation
    do_reset();
    start_game();
    chk("run_state", 32'(state_out), 1);
    chk("run_running", 32'(running), 1);
    for (int i = 0; i < 8; i++)
      expect_tick_at(tick_tab[i].edge_n, tick_tab[i].exp_ramp, tick_tab[i].exp_period);

    // 3: pause 25 cycles starting 3 cycles after a tick
    do_reset();
    start_game();
    expect_tick_at(10, 0, 10);
    step(); step();
    pause = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      chk("pause_state", 32'(state_out), 2);
      chk("pause_tick", 32'(tick), 0);
      chk("pause_running", 32'(running), 0);
    end
    pause = 1'b0;
    expect_tick_at(45, 1, 7);

    // 4: game_over on terminal count
    do_reset();
    start_game();
    expect_tick_at(10, 0, 10);
    while (k < 19) step();
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    chk("go_tc_tick", 32'(tick), 0);
    chk("go_tc_ramp", 32'(ramp_evt), 0);
    chk("go_tc_state", 32'(state_out), 3);
    chk("go_tc_period", 32'(period_out), 10);
    repeat (12) begin
      step();
      chk("over_tick", 32'(tick), 0);
    end
    start_game();
    chk("restart_state", 32'(state_out), 1);
    chk("restart_period", 32'(period_out), 10);
    expect_tick_at(10, 0, 10);

    // 5: asynchronous reset mid-RUN, on a ramp tick
    do_reset();
    start_game();
    expect_tick_at(10, 0, 10);
    expect_tick_at(20, 1, 7);
    #3 reset = 1'b1;
    #1;
    chk("arst_tick", 32'(tick), 0);
    chk("arst_ramp", 32'(ramp_evt), 0);
    chk("arst_running", 32'(running), 0);
    chk("arst_state", 32'(state_out), 0);
    chk("arst_period", 32'(period_out), 10);

    // 6: start ignored in RUN, then pause+game_over together
    do_reset();
    start_game();
    while (k < 5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    expect_tick_at(10, 0, 10);
    expect_tick_at(20, 1, 7);
    step(); step();
    pause = 1'b1; game_over = 1'b1;
    step();
    pause = 1'b0; game_over = 1'b0;
    chk("pg_state", 32'(state_out), 3);
    repeat (30) begin
      step();
      chk("pg_tick", 32'(tick), 0);
      chk("pg_state_hold", 32'(state_out), 3);
    end
    chk("pg_period", 32'(period_out), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d: got running expected finished", k);
    $fatal(1, "timeout");
  end

endmodule
